// File: rtl/vga_1bit_pkg.sv
// Shared CSR map, register bit positions and fetch FSM encoding for the VGA frame fetch block.
package vga_1bit_pkg;

  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_STATUS = 3'd1;
  localparam logic [2:0] CSR_BASE   = 3'd2;
  localparam logic [2:0] CSR_LENGTH = 3'd3;
  localparam logic [2:0] CSR_FRAMES = 3'd4;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_EOF_BIT  = 1;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_SPACE = 2'd1;
  localparam logic [1:0] ST_REQ        = 2'd2;
  localparam logic [1:0] ST_PUSH       = 2'd3;

endpackage

// File: rtl/vga_fetch_csr.sv
// CSR register file for the frame fetch: combinational read mux, writes land on the next edge.
// Never stalls the slave; an end-of-frame event beats a same-cycle write-1-clear of eof_pend.
module vga_fetch_csr
  import vga_1bit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        busy,
  input  logic        eof_set,
  output logic        enable,
  output logic [31:0] base,
  output logic [23:0] length
);

  logic        irq_en;
  logic        eof_pend;
  logic [31:0] frames;
  logic        wr_sel;

  always_comb wr_sel = chipselect & write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      eof_pend <= 1'b0;
      base     <= '0;
      length   <= '0;
      frames   <= '0;
    end else begin
      if (wr_sel) begin
        case (address)
          CSR_CTRL: begin
            enable <= writedata[CTRL_ENABLE_BIT];
            irq_en <= writedata[CTRL_IRQ_EN_BIT];
          end
          CSR_BASE:   base   <= {writedata[31:1], 1'b0};
          CSR_LENGTH: length <= writedata[23:0];
          default: ;
        endcase
      end
      if (eof_set) begin
        eof_pend <= 1'b1;
        frames   <= frames + 32'd1;
      end else if (wr_sel && address == CSR_STATUS && writedata[STATUS_EOF_BIT]) begin
        eof_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        CSR_CTRL: begin
          readdata[CTRL_ENABLE_BIT] = enable;
          readdata[CTRL_IRQ_EN_BIT] = irq_en;
        end
        CSR_STATUS: begin
          readdata[STATUS_BUSY_BIT] = busy;
          readdata[STATUS_EOF_BIT]  = eof_pend;
        end
        CSR_BASE:   readdata = base;
        CSR_LENGTH: readdata = {8'd0, length};
        CSR_FRAMES: readdata = frames;
        default:    readdata = '0;
      endcase
    end
  end

  always_comb irq = eof_pend & irq_en;

endmodule

// File: rtl/vga_frame_fetch.sv
// Frame-buffer fetch DMA feeding the VGA pixel FIFO; one word per 3 clk minimum, one read outstanding.
// Stalls on avm waitrequest, on FIFO fill >= HIGH_WATER before a read, and on fifo_wrfull before a push.
module vga_frame_fetch
  import vga_1bit_pkg::*;
#(
  parameter int FIFO_AW    = 12,
  parameter int HIGH_WATER = 3840,
  parameter int ADDR_STEP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               avs_s1_chipselect,
  input  logic [2:0]         avs_s1_address,
  input  logic               avs_s1_read,
  input  logic               avs_s1_write,
  input  logic [31:0]        avs_s1_writedata,
  output logic [31:0]        avs_s1_readdata,
  output logic               avs_s1_waitrequest,
  output logic               avs_s1_irq,
  output logic [31:0]        avm_read_address,
  output logic               avm_read_read,
  input  logic [15:0]        avm_read_readdata,
  input  logic               avm_read_waitrequest,
  output logic               fifo_write_write,
  output logic [15:0]        fifo_write_writedata,
  input  logic [FIFO_AW-1:0] fifo_wrusedw,
  input  logic               fifo_wrfull
);

  localparam logic [31:0] HW_LIMIT = HIGH_WATER;
  localparam logic [31:0] STEP     = ADDR_STEP;

  logic [1:0]  state;
  logic [31:0] addr;
  logic [23:0] cnt;
  logic [15:0] data;
  logic        enable;
  logic [31:0] base;
  logic [23:0] length;
  logic        push;
  logic        last_word;
  logic        space_ok;

  vga_fetch_csr u_csr (
    .clk        (clk),
    .reset      (reset),
    .chipselect (avs_s1_chipselect),
    .address    (avs_s1_address),
    .read       (avs_s1_read),
    .write      (avs_s1_write),
    .writedata  (avs_s1_writedata),
    .readdata   (avs_s1_readdata),
    .irq        (avs_s1_irq),
    .busy       (state != ST_IDLE),
    .eof_set    (push && last_word),
    .enable     (enable),
    .base       (base),
    .length     (length)
  );

  // LENGTH is compared live, so shrinking it below cnt only ends the frame at the 24-bit wrap.
  always_comb begin
    push      = (state == ST_PUSH) && !fifo_wrfull;
    last_word = (cnt == length - 24'd1);
    space_ok  = 32'(fifo_wrusedw) < HW_LIMIT;
  end

  always_comb begin
    avs_s1_waitrequest   = 1'b0;
    avm_read_read        = (state == ST_REQ);
    avm_read_address     = addr;
    fifo_write_write     = push;
    fifo_write_writedata = data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      cnt   <= '0;
      data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && length != 24'd0) begin
            addr  <= base;
            cnt   <= '0;
            state <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (!enable)       state <= ST_IDLE;
          else if (space_ok) state <= ST_REQ;
        end
        // An issued read always completes, even if enable drops meanwhile.
        ST_REQ: begin
          if (!avm_read_waitrequest) begin
            data  <= avm_read_readdata;
            state <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (!fifo_wrfull) begin
            if (last_word) begin
              addr <= base;
              cnt  <= '0;
            end else begin
              addr <= addr + STEP;
              cnt  <= cnt + 24'd1;
            end
            state <= enable ? ST_WAIT_SPACE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Self-checking bench for vga_frame_fetch: CSR vector table, directed corner sequences and randomized frames.
module tb_vga_frame_fetch;
  import vga_1bit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  adr = 3'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] rdat;
  logic        s1_wait, irq;
  logic [31:0] m_addr;
  logic        m_read;
  logic [15:0] m_rdata;
  logic        m_wait = 1'b0;
  logic        f_write;
  logic [15:0] f_data;
  logic [11:0] wrusedw = 12'd0;
  logic        wrfull = 1'b0;
  logic [15:0] salt = 16'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] read_q[$];
  logic [15:0] acc_q[$];
  logic [15:0] push_q[$];
  int          push_cyc[$];
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  vga_frame_fetch dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_s1_chipselect    (cs),
    .avs_s1_address       (adr),
    .avs_s1_read          (rd),
    .avs_s1_write         (wr),
    .avs_s1_writedata     (wdat),
    .avs_s1_readdata      (rdat),
    .avs_s1_waitrequest   (s1_wait),
    .avs_s1_irq           (irq),
    .avm_read_address     (m_addr),
    .avm_read_read        (m_read),
    .avm_read_readdata    (m_rdata),
    .avm_read_waitrequest (m_wait),
    .fifo_write_write     (f_write),
    .fifo_write_writedata (f_data),
    .fifo_wrusedw         (wrusedw),
    .fifo_wrfull          (wrfull)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer contents as a pure function of the byte address; salt perturbs it per cycle.
  function automatic logic [15:0] mem(input logic [31:0] a);
    return a[15:0] ^ 16'hBEEF ^ {a[23:16], a[31:24]};
  endfunction
  assign m_rdata = mem(m_addr) ^ salt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus monitor: accepted reads, FIFO pushes, and request stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend) begin
        check("req_hold_read", 32'(m_read), 32'd1);
        check("req_hold_addr", m_addr, prev_addr);
      end
      if (m_read && !m_wait) begin
        read_q.push_back(m_addr);
        acc_q.push_back(m_rdata);
      end
      if (f_write) begin
        push_q.push_back(f_data);
        push_cyc.push_back(cyc);
        check("push_not_full", 32'(wrfull), 32'd0);
      end
      prev_pend <= m_read && m_wait;
      prev_addr <= m_addr;
    end
  end

  task automatic clear_q();
    read_q.delete();
    acc_q.delete();
    push_q.delete();
    push_cyc.delete();
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; adr = a;
    #2;
    d = rdat;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] s;
    int k;
    s = 32'd1;
    k = 0;
    while (s[STATUS_BUSY_BIT] && k < 100) begin
      @(posedge clk); #1;
      csr_read(CSR_STATUS, s);
      k++;
    end
    check(nm, 32'(s[STATUS_BUSY_BIT]), 32'd0);
  endtask

  task automatic wait_pushes(input int n, input string nm);
    int k;
    k = 0;
    while (push_q.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check(nm, 32'(push_q.size() >= n), 32'd1);
  endtask

  task automatic wait_reads(input int n, input string nm);
    int k;
    k = 0;
    while (read_q.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check(nm, 32'(read_q.size() >= n), 32'd1);
  endtask

  // Reference: word i of a run is read from base + 2*(i mod len) and pushed unchanged.
  task automatic rand_round(input logic [31:0] b, input int len, input int ncyc);
    logic [31:0] f0, f1, eb, ea;
    csr_write(CSR_STATUS, 32'h2);
    csr_write(CSR_BASE, b);
    csr_write(CSR_LENGTH, 32'(len));
    csr_read(CSR_FRAMES, f0);
    clear_q();
    csr_write(CSR_CTRL, 32'h1);
    repeat (ncyc) begin
      @(posedge clk); #1;
      m_wait = ($urandom_range(0, 2) == 0);
      wrfull = ($urandom_range(0, 3) == 0);
      salt   = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       wrusedw = 12'd0;
        1:       wrusedw = 12'd3839;
        2:       wrusedw = 12'd3840;
        default: wrusedw = 12'd4095;
      endcase
    end
    @(posedge clk); #1;
    m_wait = 1'b0; wrfull = 1'b0; wrusedw = 12'd0; salt = 16'd0;
    csr_write(CSR_CTRL, 32'h0);
    wait_idle("rnd_idle");
    eb = {b[31:1], 1'b0};
    check("rnd_progress", 32'(push_q.size() > 0), 32'd1);
    check("rnd_count", 32'(read_q.size()), 32'(push_q.size()));
    for (int i = 0; i < push_q.size() && i < read_q.size(); i++) begin
      ea = eb + 32'(2 * (i % len));
      check("rnd_addr", read_q[i], ea);
      check("rnd_data", 32'(push_q[i]), 32'(acc_q[i]));
    end
    csr_read(CSR_FRAMES, f1);
    check("rnd_frames", f1, f0 + 32'(push_q.size() / len));
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic        do_wr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        found;

    tbl[0]  = '{CSR_BASE,   1'b1, 32'h1234_5679, 32'h1234_5678};
    tbl[1]  = '{CSR_LENGTH, 1'b1, 32'hFFAB_CDEF, 32'h00AB_CDEF};
    tbl[2]  = '{CSR_CTRL,   1'b1, 32'hFFFF_FFFE, 32'h0000_0002};
    tbl[3]  = '{CSR_STATUS, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[4]  = '{CSR_FRAMES, 1'b1, 32'h0000_1234, 32'h0000_0000};
    tbl[5]  = '{3'd5,       1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6]  = '{3'd6,       1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7]  = '{3'd7,       1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[8]  = '{CSR_CTRL,   1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[9]  = '{CSR_LENGTH, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[10] = '{CSR_BASE,   1'b0, 32'h0000_0000, 32'h1234_5678};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_read",   32'(m_read),  32'd0);
    check("rst_addr",   m_addr,       32'd0);
    check("rst_write",  32'(f_write), 32'd0);
    check("rst_wdata",  32'(f_data),  32'd0);
    check("rst_irq",    32'(irq),     32'd0);
    check("rst_s1wait", 32'(s1_wait), 32'd0);
    for (int i = 0; i < 5; i++) begin
      csr_read(3'(i), r);
      check($sformatf("rst_csr%0d", i), r, 32'd0);
      @(posedge clk); #1;
    end

    // CSR vector table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_wr) csr_write(tbl[i].idx, tbl[i].wdat);
      csr_read(tbl[i].idx, r);
      check($sformatf("csr_vec%0d", i), r, tbl[i].exp);
    end
    adr = CSR_BASE; rd = 1'b1; #1;
    check("rdata_no_cs", rdat, 32'd0);
    rd = 1'b0;

    // LENGTH=0 with enable: stays idle
    clear_q();
    csr_write(CSR_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check("len0_no_reads", 32'(read_q.size()), 32'd0);
    csr_read(CSR_STATUS, r);
    check("len0_busy", 32'(r[STATUS_BUSY_BIT]), 32'd0);
    csr_write(CSR_CTRL, 32'h0);

    // Basic frame walk
    csr_write(CSR_BASE, 32'h1000);
    csr_write(CSR_LENGTH, 32'd4);
    clear_q();
    csr_write(CSR_CTRL, 32'h1);
    wait_pushes(4, "f1_wait4");
    csr_read(CSR_FRAMES, r);
    check("f1_frames_after4", r, 32'd1);
    csr_read(CSR_STATUS, r);
    check("f1_eof_pend", 32'(r[STATUS_EOF_BIT]), 32'd1);
    wait_reads(5, "f1_wait5r");
    csr_write(CSR_CTRL, 32'h0);
    wait_idle("f1_idle");
    for (int i = 0; i < 5 && i < read_q.size(); i++)
      check($sformatf("f1_addr%0d", i), read_q[i], 32'h1000 + 32'(2 * (i % 4)));
    for (int i = 0; i < 4 && i < push_q.size(); i++)
      check($sformatf("f1_data%0d", i), 32'(push_q[i]), 32'(mem(32'h1000 + 32'(2 * i))));
    for (int i = 1; i < 4 && i < push_cyc.size(); i++)
      check($sformatf("f1_gap%0d", i), 32'(push_cyc[i] - push_cyc[i-1]), 32'd3);
    csr_write(CSR_STATUS, 32'h2);

    // Wait states, with enable dropped mid-request
    csr_write(CSR_BASE, 32'h2000);
    csr_write(CSR_LENGTH, 32'd1);
    clear_q();
    m_wait = 1'b1;
    csr_write(CSR_CTRL, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = m_read;
    end
    check("ws_req_seen", 32'(found), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        cs = 1'b1; wr = 1'b1; adr = CSR_CTRL; wdat = 32'h0;
      end else begin
        cs = 1'b0; wr = 1'b0;
      end
      salt = 16'($urandom);
      @(negedge clk);
      check("ws_hold_read", 32'(m_read), 32'd1);
      check("ws_hold_addr", m_addr, 32'h2000);
      check("ws_no_push", 32'(f_write), 32'd0);
    end
    @(posedge clk); #1;
    salt = 16'h5A5A; m_wait = 1'b0;
    @(posedge clk); #1;
    m_wait = 1'b1; salt = 16'd0;
    repeat (4) @(posedge clk);
    #1;
    check("ws_one_push", 32'(push_q.size()), 32'd1);
    check("ws_one_read", 32'(read_q.size()), 32'd1);
    check("ws_data", 32'(push_q.size() > 0 ? push_q[0] : 16'h0), 32'(mem(32'h2000) ^ 16'h5A5A));
    wait_idle("ws_idle");
    m_wait = 1'b0;
    csr_write(CSR_STATUS, 32'h2);

    // High-water gating and FIFO-full hold
    csr_write(CSR_BASE, 32'h3000);
    csr_write(CSR_LENGTH, 32'd2);
    clear_q();
    wrusedw = 12'd3840;
    csr_write(CSR_CTRL, 32'h1);
    found = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m_read) found = 1'b1;
    end
    check("hw_no_read", 32'(found), 32'd0);
    @(posedge clk); #1;
    wrusedw = 12'd3839; wrfull = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hw_req_next", 32'(m_read), 32'd1);
    check("hw_req_addr", m_addr, 32'h3000);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_no_write", 32'(f_write), 32'd0);
    end
    @(posedge clk); #1;
    wrfull = 1'b0;
    @(negedge clk);
    check("full_then_write", 32'(f_write), 32'd1);
    check("full_then_data", 32'(f_data), 32'(mem(32'h3000)));
    @(posedge clk); #1;
    wrusedw = 12'd3840;
    csr_write(CSR_CTRL, 32'h0);
    wait_idle("hw_idle");
    check("hw_push_count", 32'(push_q.size()), 32'd1);
    wrusedw = 12'd0;

    // Interrupt and set-beats-clear
    csr_write(CSR_STATUS, 32'h2);
    csr_write(CSR_BASE, 32'h4000);
    csr_write(CSR_LENGTH, 32'd2);
    clear_q();
    csr_write(CSR_CTRL, 32'h3);
    wait_pushes(1, "irq_wait1");
    check("irq_after_1st", 32'(irq), 32'd0);
    wait_pushes(2, "irq_wait2");
    wrusedw = 12'd3840;
    check("irq_after_2nd", 32'(irq), 32'd1);
    csr_write(CSR_STATUS, 32'h2);
    check("irq_cleared", 32'(irq), 32'd0);
    wrfull = 1'b1; wrusedw = 12'd0;
    wait_reads(3, "irq_wait_r3");
    wrfull = 1'b0;
    @(posedge clk); #1;
    wrfull = 1'b1;
    wait_reads(4, "irq_wait_r4");
    wrfull = 1'b0;
    cs = 1'b1; wr = 1'b1; adr = CSR_STATUS; wdat = 32'h2;
    @(negedge clk);
    check("race_eof_push", 32'(f_write), 32'd1);
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; wrusedw = 12'd3840;
    check("race_irq", 32'(irq), 32'd1);
    csr_read(CSR_STATUS, r);
    check("race_eof_pend", 32'(r[STATUS_EOF_BIT]), 32'd1);
    csr_write(CSR_CTRL, 32'h0);
    wait_idle("irq_idle");
    wrusedw = 12'd0;
    csr_write(CSR_STATUS, 32'h2);

    // Randomized frames, including a base that wraps past 2^32
    rand_round(32'h0000_8000 | 32'($urandom_range(0, 255)), 3, 400);
    rand_round(32'hFFFF_FFFB, 5, 400);

    // Reset asserted mid-PUSH
    csr_write(CSR_STATUS, 32'h2);
    csr_write(CSR_BASE, 32'h5000);
    csr_write(CSR_LENGTH, 32'd1);
    clear_q();
    csr_write(CSR_CTRL, 32'h3);
    wait_pushes(1, "rst_wait_p1");
    wrfull = 1'b1;
    wait_reads(2, "rst_wait_r2");
    @(posedge clk); #3;
    check("pre_rst_irq", 32'(irq), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_read",  32'(m_read),  32'd0);
    check("mid_rst_addr",  m_addr,       32'd0);
    check("mid_rst_write", 32'(f_write), 32'd0);
    check("mid_rst_wdata", 32'(f_data),  32'd0);
    check("mid_rst_irq",   32'(irq),     32'd0);
    csr_read(CSR_CTRL, r);
    check("mid_rst_ctrl", r, 32'd0);
    @(posedge clk); #1;
    wrfull = 1'b0;
    clear_q();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      csr_read(3'(i), r);
      check($sformatf("post_rst_csr%0d", i), r, 32'd0);
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_push", 32'(push_q.size()), 32'd0);
    check("post_rst_no_read", 32'(read_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
